// File: rtl/safe_lock_ctrl.sv
// Keypad sequencing controller for the safe lock: code entry, check, timed open, failure lockout.
// Optional runtime code change while open is enabled by defining CODE_CHANGE_EN.
module safe_lock_ctrl #(
  parameter int unsigned        NDIG         = 4,
  parameter int unsigned        MAX_FAIL     = 3,
  parameter int unsigned        OPEN_CYC     = 500,
  parameter int unsigned        LOCK_CYC     = 1000,
  parameter logic [NDIG*4-1:0]  DEFAULT_CODE = 16'h1234,
  parameter logic [4:0]         KEY_ENTER    = 5'd21,
  parameter logic [4:0]         KEY_CLEAR    = 5'd20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [4:0] key,
  output logic       unlock,
  output logic       alarm,
  output logic       err,
  output logic [3:0] fail_cnt,
  output logic [3:0] digit_cnt,
  output logic [2:0] state_o
);

  localparam int unsigned BW   = NDIG * 4;
  localparam int unsigned TMAX = (OPEN_CYC > LOCK_CYC) ? OPEN_CYC : LOCK_CYC;
  localparam int unsigned TW   = $clog2(TMAX);
  localparam logic [TW-1:0] OPEN_LOAD  = TW'(OPEN_CYC - 1);
  localparam logic [TW-1:0] LOCK_LOAD  = TW'(LOCK_CYC - 1);
  localparam logic [3:0]    NDIG_C     = 4'(NDIG);
  localparam logic [3:0]    MAX_FAIL_C = 4'(MAX_FAIL);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_LOCKOUT = 3'd4,
    S_NEWCODE = 3'd5
  } state_t;

  state_t          state_r, state_nxt;
  logic [BW-1:0]   buf_r, buf_nxt;
  logic [3:0]      cnt_r, cnt_nxt;
  logic            ovf_r, ovf_nxt;
  logic [3:0]      fail_r, fail_nxt;
  logic [TW-1:0]   timer_r, timer_nxt;
  logic            err_nxt;
  logic            unlock_r, alarm_r, err_r;
  logic [BW-1:0]   code_s;
  logic [BW-1:0]   buf_shift_s;
  logic            is_digit_s, is_enter_s, is_clear_s, match_s;

`ifdef CODE_CHANGE_EN
  logic [BW-1:0]   code_r, code_nxt;
  assign code_s = code_r;
`else
  assign code_s = DEFAULT_CODE;
`endif

  assign is_digit_s  = key_valid && (key <= 5'd9);
  assign is_enter_s  = key_valid && (key == KEY_ENTER);
  assign is_clear_s  = key_valid && (key == KEY_CLEAR);
  assign buf_shift_s = (buf_r << 4) | BW'(key[3:0]);
  assign match_s     = (cnt_r == NDIG_C) && !ovf_r && (buf_r == code_s);

  // Next-state and datapath update for the whole controller
  always_comb begin
    state_nxt = state_r;
    buf_nxt   = buf_r;
    cnt_nxt   = cnt_r;
    ovf_nxt   = ovf_r;
    fail_nxt  = fail_r;
    timer_nxt = timer_r;
    err_nxt   = 1'b0;
`ifdef CODE_CHANGE_EN
    code_nxt  = code_r;
`endif
    case (state_r)
      S_IDLE, S_ENTRY: begin
        if (is_digit_s) begin
          buf_nxt   = buf_shift_s;
          state_nxt = S_ENTRY;
          if (cnt_r == NDIG_C) begin
            ovf_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt_r + 4'd1;
          end
        end else if (is_clear_s) begin
          buf_nxt   = '0;
          cnt_nxt   = 4'd0;
          ovf_nxt   = 1'b0;
          state_nxt = S_IDLE;
        end else if (is_enter_s && (state_r == S_ENTRY)) begin
          state_nxt = S_CHECK;
        end else begin
          state_nxt = state_r;
        end
      end
      S_CHECK: begin
        buf_nxt = '0;
        cnt_nxt = 4'd0;
        ovf_nxt = 1'b0;
        if (match_s) begin
          state_nxt = S_OPEN;
          fail_nxt  = 4'd0;
          timer_nxt = OPEN_LOAD;
        end else begin
          err_nxt  = 1'b1;
          fail_nxt = fail_r + 4'd1;
          if ((fail_r + 4'd1) == MAX_FAIL_C) begin
            state_nxt = S_LOCKOUT;
            timer_nxt = LOCK_LOAD;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_OPEN: begin
        // Expiry is tested first so a key arriving on the last cycle is dropped
        if (timer_r == '0) begin
          state_nxt = S_IDLE;
        end else begin
          timer_nxt = timer_r - TW'(1);
          if (is_enter_s) begin
            state_nxt = S_IDLE;
`ifdef CODE_CHANGE_EN
          end else if (is_clear_s) begin
            state_nxt = S_NEWCODE;
            buf_nxt   = '0;
            cnt_nxt   = 4'd0;
            ovf_nxt   = 1'b0;
`endif
          end else begin
            state_nxt = S_OPEN;
          end
        end
      end
      S_LOCKOUT: begin
        if (timer_r == '0) begin
          state_nxt = S_IDLE;
          fail_nxt  = 4'd0;
        end else begin
          timer_nxt = timer_r - TW'(1);
        end
      end
`ifdef CODE_CHANGE_EN
      S_NEWCODE: begin
        if (is_digit_s) begin
          buf_nxt = buf_shift_s;
          if (cnt_r == NDIG_C) begin
            ovf_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt_r + 4'd1;
          end
        end else if (is_enter_s || is_clear_s) begin
          if (is_enter_s && (cnt_r == NDIG_C) && !ovf_r) begin
            code_nxt  = buf_r;
            timer_nxt = OPEN_LOAD;
          end else begin
            timer_nxt = timer_r;
          end
          state_nxt = S_OPEN;
          buf_nxt   = '0;
          cnt_nxt   = 4'd0;
          ovf_nxt   = 1'b0;
        end else begin
          state_nxt = S_NEWCODE;
        end
      end
`endif
      default: begin
        state_nxt = S_IDLE;
        buf_nxt   = '0;
        cnt_nxt   = 4'd0;
        ovf_nxt   = 1'b0;
      end
    endcase
  end

  // State, datapath and registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= S_IDLE;
      buf_r    <= '0;
      cnt_r    <= 4'd0;
      ovf_r    <= 1'b0;
      fail_r   <= 4'd0;
      timer_r  <= '0;
      unlock_r <= 1'b0;
      alarm_r  <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_nxt;
      buf_r    <= buf_nxt;
      cnt_r    <= cnt_nxt;
      ovf_r    <= ovf_nxt;
      fail_r   <= fail_nxt;
      timer_r  <= timer_nxt;
      unlock_r <= (state_nxt == S_OPEN) || (state_nxt == S_NEWCODE);
      alarm_r  <= (state_nxt == S_LOCKOUT);
      err_r    <= err_nxt;
    end
  end

`ifdef CODE_CHANGE_EN
  // Stored code register, loaded only from NEWCODE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code_r <= DEFAULT_CODE;
    end else begin
      code_r <= code_nxt;
    end
  end
`endif

  assign unlock    = unlock_r;
  assign alarm     = alarm_r;
  assign err       = err_r;
  assign fail_cnt  = fail_r;
  assign digit_cnt = cnt_r;
  assign state_o   = state_r;

endmodule

// File: tb/tb_safe_lock_ctrl.sv
// Self-checking bench for safe_lock_ctrl: directed scenarios plus random keys against a
// digit-queue reference model. Honours CODE_CHANGE_EN when defined.
module tb_safe_lock_ctrl;

  localparam int NDIG     = 4;
  localparam int MAX_FAIL = 3;
  localparam int OPEN_CYC = 500;
  localparam int LOCK_CYC = 1000;
  localparam int K_ENT    = 21;
  localparam int K_CLR    = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [4:0] key;
  logic       unlock, alarm, err;
  logic [3:0] fail_cnt, digit_cnt;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  // reference model: entered digits as a queue, timers as remaining-cycle counts
  int m_mode;
  int m_q[$];
  int m_code[$];
  bit m_ovf;
  int m_fail;
  int m_left;
  bit m_err;

  safe_lock_ctrl #(
    .NDIG(NDIG), .MAX_FAIL(MAX_FAIL), .OPEN_CYC(OPEN_CYC), .LOCK_CYC(LOCK_CYC),
    .DEFAULT_CODE(16'h1234), .KEY_ENTER(5'd21), .KEY_CLEAR(5'd20)
  ) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key(key),
    .unlock(unlock), .alarm(alarm), .err(err),
    .fail_cnt(fail_cnt), .digit_cnt(digit_cnt), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    logic [15:0] dc;
    dc = 16'h1234;
    m_mode = 0;
    m_q.delete();
    m_code.delete();
    for (int i = 0; i < NDIG; i++) m_code.push_back(int'(dc[15-4*i -: 4]));
    m_ovf  = 1'b0;
    m_fail = 0;
    m_left = 0;
    m_err  = 1'b0;
  endtask

  task automatic m_push(input int d);
    m_q.push_back(d);
    if (m_q.size() > NDIG) begin
      void'(m_q.pop_front());
      m_ovf = 1'b1;
    end
  endtask

  task automatic m_step(input bit v, input int k);
    bit dig, ent, clr, ok;
    dig = v && (k <= 9);
    ent = v && (k == K_ENT);
    clr = v && (k == K_CLR);
    m_err = 1'b0;
    case (m_mode)
      0, 1: begin
        if (dig) begin
          m_push(k);
          m_mode = 1;
        end else if (clr) begin
          m_q.delete(); m_ovf = 1'b0; m_mode = 0;
        end else if (ent && m_mode == 1) begin
          m_mode = 2;
        end
      end
      2: begin
        ok = (m_q.size() == NDIG) && !m_ovf;
        for (int i = 0; i < m_q.size() && i < NDIG; i++) if (m_q[i] != m_code[i]) ok = 1'b0;
        m_q.delete(); m_ovf = 1'b0;
        if (ok) begin
          m_mode = 3; m_fail = 0; m_left = OPEN_CYC;
        end else begin
          m_err = 1'b1; m_fail++;
          if (m_fail == MAX_FAIL) begin m_mode = 4; m_left = LOCK_CYC; end
          else m_mode = 0;
        end
      end
      3: begin
        m_left--;
        if (m_left == 0 || ent) m_mode = 0;
`ifdef CODE_CHANGE_EN
        else if (clr) begin m_mode = 5; m_q.delete(); m_ovf = 1'b0; end
`endif
      end
      4: begin
        m_left--;
        if (m_left == 0) begin m_mode = 0; m_fail = 0; end
      end
      5: begin
        if (dig) m_push(k);
        else if (ent || clr) begin
          if (ent && m_q.size() == NDIG && !m_ovf) begin
            m_code = m_q; m_left = OPEN_CYC;
          end
          m_q.delete(); m_ovf = 1'b0; m_mode = 3;
        end
      end
      default: m_mode = 0;
    endcase
  endtask

  task automatic compare_all();
    check_val("unlock", unlock, (m_mode == 3 || m_mode == 5));
    check_val("alarm", alarm, (m_mode == 4));
    check_val("err", err, m_err);
    check_val("fail_cnt", fail_cnt, m_fail);
    check_val("digit_cnt", digit_cnt, m_q.size());
    check_val("state", state_o, m_mode);
  endtask

  // one clock: drive, advance model at the edge, compare just after it
  task automatic cycle(input bit v, input int k);
    key_valid = v;
    key = 5'(k);
    @(posedge clk);
    m_step(v, k);
    #1;
    compare_all();
  endtask

  task automatic press(input int seq[$]);
    foreach (seq[i]) cycle(1'b1, seq[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0);
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b0;
    #1;
    m_reset();
    compare_all();
    check_val("rst_state", state_o, 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  int seen;
  int r;

  initial begin
    rst = 1'b0;
    key_valid = 1'b0;
    key = 5'd0;
    m_reset();
    #12;
    compare_all();
    @(negedge clk);
    rst = 1'b1;

    // 1: correct code, open window length
    press('{1, 2, 3, 4, K_ENT});
    seen = 0;
    for (int i = 0; i < OPEN_CYC + 5; i++) begin
      cycle(1'b0, 0);
      if (unlock === 1'b1) seen++;
    end
    check_val("open_len", seen, OPEN_CYC);

    // 2: wrong code then right code, closed early by ENTER
    press('{1, 2, 3, 5, K_ENT});
    idle(2);
    check_val("fail_after_wrong", fail_cnt, 1);
    press('{1, 2, 3, 4, K_ENT});
    idle(3);
    press('{7, K_ENT});
    idle(2);

    // 3: lockout, correct code ignored while locked
    for (int a = 0; a < MAX_FAIL; a++) begin
      press('{9, 9, 9, 9, K_ENT});
      idle(1);
    end
    press('{1, 2, 3, 4, K_ENT});
    seen = 0;
    for (int i = 0; i < LOCK_CYC + 5; i++) begin
      cycle(1'b0, 0);
      if (alarm === 1'b1) seen++;
    end
    check_val("lock_len_tail", seen, LOCK_CYC - 6);

    // 4: edge entries
    press('{1, 2, 3, 4, 5, K_ENT});
    idle(2);
    press('{1, 2, 3, K_ENT});
    idle(2);
    press('{1, 2, K_CLR, 1, 2, 3, 4, K_ENT});
    idle(2);
    press('{K_ENT});
    idle(OPEN_CYC);
    press('{K_ENT, 13, 31});
    idle(2);

    // 5: async reset mid-lockout and mid-open
    for (int a = 0; a < MAX_FAIL; a++) press('{9, 9, 9, 9, K_ENT});
    idle(10);
    async_reset();
    idle(2);
    press('{1, 2, 3, 4, K_ENT});
    idle(10);
    async_reset();
    idle(2);

    // 6: code change attempt (effect depends on CODE_CHANGE_EN)
    press('{1, 2, 3, 4, K_ENT});
    idle(3);
    press('{K_CLR, 5, 6, 7, 8, K_ENT});
    idle(3);
    press('{K_ENT});
    idle(2);
    press('{1, 2, 3, 4, K_ENT});
    idle(2);
    press('{5, 6, 7, 8, K_ENT});
    idle(3);
    press('{K_ENT});
    idle(2);

    // random keys, biased towards plausible codes
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 20)      cycle(1'b0, $urandom_range(0, 31));
      else if (r < 65) cycle(1'b1, $urandom_range(1, 8));
      else if (r < 78) cycle(1'b1, K_ENT);
      else if (r < 86) cycle(1'b1, K_CLR);
      else             cycle(1'b1, $urandom_range(0, 31));
      if (i == 2500) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
